// File: rtl/calc_controller_if.sv
// calc_controller_if: keypad strobes in, display value and status flags out.
// master = keypad side (drives strobes), slave = calc_controller.
interface calc_controller_if #(
  parameter int WIDTH = 16
);
  logic             newhex;
  logic [3:0]       hexcode;
  logic             newop;
  logic [1:0]       opcode;
  logic             eq;
  logic [WIDTH-1:0] display;
  logic             neg;
  logic             ovf;
  logic             op_pend;

  modport master (
    output newhex, hexcode, newop, opcode, eq,
    input  display, neg, ovf, op_pend
  );

  modport slave (
    input  newhex, hexcode, newop, opcode, eq,
    output display, neg, ovf, op_pend
  );
endinterface

// File: rtl/calc_controller.sv
// calc_controller: hex operand entry, pending operator, add/sub/mul eval.
// Ports: clk, rst_n (async low), bus (slave: strobes in, display/flags out).
// CALC_OVF_DETECT_EN: when defined, ovf tracks add carry / mul truncation.
module calc_controller #(
  parameter int WIDTH = 16
) (
  input logic              clk,
  input logic              rst_n,
  calc_controller_if.slave bus
);
  localparam int DIGITS = WIDTH / 4;
  localparam int NW = $clog2(DIGITS + 1);
  localparam logic [NW-1:0] DIG = NW'(DIGITS);

  typedef enum logic [1:0] {
    ENTRY_A, OP_WAIT, ENTRY_B, RESULT
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] entry_q, entry_d;
  logic [1:0]       op_q, op_d;
  logic [NW-1:0]    ndig_q, ndig_d;
  logic             neg_q;
  logic             hex_q, opk_q, eq_q;
  logic             eq_e, op_e, hex_e;
  logic             upd, clr;

  // Rising-edge detect with eq > op > hex priority.
  assign eq_e  = bus.eq & ~eq_q;
  assign op_e  = bus.newop & ~opk_q & ~eq_e;
  assign hex_e = bus.newhex & ~hex_q & ~eq_e & ~op_e;

  // eq while waiting on operand B folds acc with itself.
  logic [WIDTH-1:0] rhs, add_r, mul_r, res;
  logic             eval_neg;

  assign rhs = (state_q == OP_WAIT) ? acc_q : entry_q;

`ifdef CALC_OVF_DETECT_EN
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
  logic               eval_ovf;
  logic               ovf_q;

  assign sum   = {1'b0, acc_q} + {1'b0, rhs};
  assign prod  = {{WIDTH{1'b0}}, acc_q}
               * {{WIDTH{1'b0}}, rhs};
  assign add_r = sum[WIDTH-1:0];
  assign mul_r = prod[WIDTH-1:0];

  always_comb begin
    eval_ovf = 1'b0;
    unique case (op_q)
      2'b01:   eval_ovf = |prod[2*WIDTH-1:WIDTH];
      2'b10:   eval_ovf = 1'b0;
      default: eval_ovf = sum[WIDTH];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (clr) begin
      ovf_q <= 1'b0;
    end else if (upd) begin
      ovf_q <= eval_ovf;
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign add_r   = acc_q + rhs;
  assign mul_r   = acc_q * rhs;
  assign bus.ovf = 1'b0;
`endif

  always_comb begin
    res = add_r;
    unique case (op_q)
      2'b01:   res = mul_r;
      2'b10:   res = acc_q - rhs;
      default: res = add_r;
    endcase
  end

  assign eval_neg = (op_q == 2'b10) && (acc_q < rhs);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ENTRY_A;
      acc_q   <= '0;
      entry_q <= '0;
      op_q    <= '0;
      ndig_q  <= '0;
      neg_q   <= 1'b0;
      hex_q   <= 1'b0;
      opk_q   <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      entry_q <= entry_d;
      op_q    <= op_d;
      ndig_q  <= ndig_d;
      hex_q   <= bus.newhex;
      opk_q   <= bus.newop;
      eq_q    <= bus.eq;
      if (clr) begin
        neg_q <= 1'b0;
      end else if (upd) begin
        neg_q <= eval_neg;
      end
    end
  end

  // Next state and datapath.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    entry_d = entry_q;
    op_d    = op_q;
    ndig_d  = ndig_q;
    upd     = 1'b0;
    clr     = 1'b0;
    unique case (1'b1)
      eq_e: begin
        unique case (state_q)
          ENTRY_A: state_d = RESULT;
          OP_WAIT, ENTRY_B: begin
            entry_d = res;
            upd     = 1'b1;
            state_d = RESULT;
          end
          default: ;
        endcase
      end
      op_e: begin
        op_d = bus.opcode;
        unique case (state_q)
          ENTRY_A, RESULT: begin
            acc_d   = entry_q;
            state_d = OP_WAIT;
          end
          ENTRY_B: begin
            acc_d   = res;
            entry_d = res;
            upd     = 1'b1;
            state_d = OP_WAIT;
          end
          default: ;
        endcase
      end
      hex_e: begin
        unique case (state_q)
          ENTRY_A, ENTRY_B: begin
            if (ndig_q != DIG) begin
              entry_d = (entry_q << 4)
                      | WIDTH'(bus.hexcode);
              ndig_d  = ndig_q + NW'(1);
            end
          end
          OP_WAIT: begin
            entry_d = WIDTH'(bus.hexcode);
            ndig_d  = NW'(1);
            state_d = ENTRY_B;
          end
          default: begin
            acc_d   = '0;
            entry_d = WIDTH'(bus.hexcode);
            ndig_d  = NW'(1);
            clr     = 1'b1;
            state_d = ENTRY_A;
          end
        endcase
      end
      default: ;
    endcase
  end

  // Outputs.
  always_comb begin
    bus.display = entry_q;
    bus.neg     = neg_q;
    bus.op_pend = (state_q == OP_WAIT);
  end
endmodule

// File: tb/tb_calc_controller.sv
// tb_calc_controller: directed and random key presses against a
// reference calculator model.
module tb_calc_controller;
  localparam int W = 16;
  localparam int MASK = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  calc_controller_if #(.WIDTH(W)) bus();

  calc_controller #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int passed = 0;
  int failed = 0;

  // Reference calculator: mode 0 typing first operand,
  // 1 operator held, 2 typing second operand, 3 showing result.
  int m_mode, m_acc, m_ent, m_op, m_nd;
  bit m_neg, m_ovf, m_held;

  task automatic m_reset();
    m_mode = 0; m_acc = 0; m_ent = 0;
    m_op = 0; m_nd = 0; m_neg = 0; m_ovf = 0;
  endtask

  task automatic m_calc(input int a, input int b, output int r);
    longint p;
    case (m_op)
      1: begin
        p = longint'(a) * longint'(b);
        m_ovf = (p > MASK);
        m_neg = 0;
      end
      2: begin
        p = longint'(a) - longint'(b);
        m_neg = (a < b);
        m_ovf = 0;
      end
      default: begin
        p = longint'(a) + longint'(b);
        m_ovf = (p > MASK);
        m_neg = 0;
      end
    endcase
    r = int'(p & MASK);
  endtask

  task automatic m_hex(input int h);
    case (m_mode)
      0, 2: if (m_nd < W / 4) begin
        m_ent = (m_ent * 16 + h) & MASK;
        m_nd++;
      end
      1: begin m_ent = h; m_nd = 1; m_mode = 2; end
      default: begin
        m_acc = 0; m_ent = h; m_nd = 1;
        m_neg = 0; m_ovf = 0; m_mode = 0;
      end
    endcase
  endtask

  task automatic m_opk(input int o);
    int r;
    case (m_mode)
      1: m_op = o;
      2: begin
        m_calc(m_acc, m_ent, r);
        m_acc = r; m_ent = r; m_op = o; m_mode = 1;
      end
      default: begin m_acc = m_ent; m_op = o; m_mode = 1; end
    endcase
  endtask

  task automatic m_eq();
    int r;
    case (m_mode)
      0: m_mode = 3;
      1: begin m_calc(m_acc, m_acc, r); m_ent = r; m_mode = 3; end
      2: begin m_calc(m_acc, m_ent, r); m_ent = r; m_mode = 3; end
      default: ;
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    bit eo;
`ifdef CALC_OVF_DETECT_EN
    eo = m_ovf;
`else
    eo = 0;
`endif
    check({tag, ".display"}, 32'(bus.display), 32'(m_ent));
    check({tag, ".neg"}, 32'(bus.neg), 32'(m_neg));
    check({tag, ".ovf"}, 32'(bus.ovf), 32'(eo));
    check({tag, ".op_pend"}, 32'(bus.op_pend), 32'(m_mode == 1));
  endtask

  // Press a combination of keys for one cycle; model takes
  // only the highest-priority one. mask: bit0 hex, bit1 op, bit2 eq.
  task automatic press(input int mask, input int h, input int o,
                       input int hold);
    @(negedge clk);
    bus.hexcode = 4'(h);
    bus.opcode  = 2'(o);
    bus.newhex  = mask[0];
    bus.newop   = mask[1];
    bus.eq      = mask[2];
    repeat (hold) @(negedge clk);
    bus.newhex = 0; bus.newop = 0; bus.eq = 0;
    if (mask[2]) m_eq();
    else if (mask[1]) m_opk(o);
    else if (mask[0]) m_hex(h);
  endtask

  task automatic hex(input int h);
    press(1, h, 0, 1);
  endtask

  task automatic opk(input int o);
    press(2, 0, o, 1);
  endtask

  task automatic eqk();
    press(4, 0, 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    m_reset();
  endtask

  initial begin
    int r;
    bus.newhex = 0; bus.newop = 0; bus.eq = 0;
    bus.hexcode = 0; bus.opcode = 0;
    rst_n = 0;
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    check_all("reset");

    hex(1); hex(2); opk(0); hex(3); eqk();
    check("add.display", 32'(bus.display), 32'h0015);
    check_all("add");

    do_reset();
    hex(5); opk(2); hex(7); eqk();
    check("sub.display", 32'(bus.display), 32'hFFFE);
    check("sub.neg", 32'(bus.neg), 32'd1);
    check_all("sub");

    do_reset();
    hex(1); hex(2); hex(3); hex(4); hex(5);
    check("digits.display", 32'(bus.display), 32'h1234);
    check_all("digits");

    do_reset();
    hex(15); hex(15); hex(15); hex(15); opk(1); hex(2); eqk();
    check("mul.display", 32'(bus.display), 32'hFFFE);
    check_all("mul");

    do_reset();
    hex(2); opk(0); hex(3); opk(0);
    check("chain.display", 32'(bus.display), 32'h0005);
    check("chain.op_pend", 32'(bus.op_pend), 32'd1);
    hex(4); eqk();
    check("chain2.display", 32'(bus.display), 32'h0009);
    check_all("chain");

    do_reset();
    hex(2); opk(0); eqk();
    check("opwait_eq.display", 32'(bus.display), 32'h0004);
    check_all("opwait_eq");

    do_reset();
    hex(2); opk(0); hex(3);
    press(4, 0, 0, 5);
    check("eqhold.display", 32'(bus.display), 32'h0005);
    check_all("eqhold");
    opk(2); hex(9); eqk();
    check("result_op.display", 32'(bus.display), 32'hFFFC);
    check_all("result_op");

    do_reset();
    press(1, 7, 0, 5);
    check("hexhold.display", 32'(bus.display), 32'h0007);
    check_all("hexhold");

    do_reset();
    hex(3); press(7, 9, 1, 1);
    check_all("simul_eq");
    press(3, 5, 1, 1);
    check_all("simul_op");

    do_reset();
    hex(1); hex(2);
    check("mid.display", 32'(bus.display), 32'h0012);
    @(negedge clk);
    #2 rst_n = 0;
    #1 check("async.display", 32'(bus.display), 32'h0000);
    check("async.op_pend", 32'(bus.op_pend), 32'd0);
    @(negedge clk);
    rst_n = 1;
    m_reset();
    hex(4);
    check("after_rst.display", 32'(bus.display), 32'h0004);
    check_all("after_rst");

    do_reset();
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 39);
      if (r == 39) begin
        do_reset();
      end else if (r < 18) begin
        hex($urandom_range(0, 15));
      end else if (r < 28) begin
        opk($urandom_range(0, 3));
      end else if (r < 34) begin
        eqk();
      end else begin
        press($urandom_range(1, 7), $urandom_range(0, 15),
              $urandom_range(0, 3), $urandom_range(1, 2));
      end
      check_all("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
